// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU select codes, MIPS opcode/funct constants and op classes.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'd0;
   localparam logic [3:0] ALU_OR   = 4'd1;
   localparam logic [3:0] ALU_ADD  = 4'd2;
   localparam logic [3:0] ALU_SUB  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_NOR  = 4'd12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;

   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef enum logic [1:0] {ARITH_ADD, ARITH_SUB, OTHER} op_class_e;

endpackage

// File: rtl/ALU_32bit.sv
// rtl/ALU_32bit.sv - combinational 32-bit ALU selected by ALU_Sel.
module ALU_32bit
   import alu_pkg::*;
(
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  ALU_Sel,
   output logic [31:0] ALU_Out,
   output logic        CarryOut
);

   logic [32:0] sum;

   assign sum      = {1'b0, A} + {1'b0, B};
   // Carry always reports the unsigned A+B, whatever the select.
   assign CarryOut = sum[32];

   always_comb begin
      ALU_Out = '0;
      case (ALU_Sel)
         ALU_AND:  ALU_Out = A & B;
         ALU_OR:   ALU_Out = A | B;
         ALU_ADD:  ALU_Out = sum[31:0];
         ALU_SUB:  ALU_Out = A - B;
         ALU_SLTU: ALU_Out = {31'd0, (A < B)};
         ALU_SLT:  ALU_Out = {31'd0, ($signed(A) < $signed(B))};
         ALU_NOR:  ALU_Out = ~(A | B);
         default:  ALU_Out = '0;
      endcase
   end

endmodule

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - maps opcode/funct/imm to ALU select, operand B, op class and err.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic [31:0] rt,
   input  logic [15:0] imm,
   output logic [3:0]  sel,
   output logic [31:0] b,
   output op_class_e   cls,
   output logic        err
);

   logic [31:0] imm_sx;
   logic [31:0] imm_zx;

   assign imm_sx = {{16{imm[15]}}, imm};
   assign imm_zx = {16'd0, imm};

   // Illegal encodings fall through with select AND and B=0.
   always_comb begin
      sel = ALU_AND;
      b   = '0;
      cls = OTHER;
      err = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            b = rt;
            case (funct)
               FN_AND:  sel = ALU_AND;
               FN_OR:   sel = ALU_OR;
               FN_ADD:  begin sel = ALU_ADD; cls = ARITH_ADD; end
               FN_ADDU: sel = ALU_ADD;
               FN_SUB:  begin sel = ALU_SUB; cls = ARITH_SUB; end
               FN_SUBU: sel = ALU_SUB;
               FN_SLTU: sel = ALU_SLTU;
               FN_SLT:  sel = ALU_SLT;
               FN_NOR:  sel = ALU_NOR;
               default: begin b = '0; err = 1'b1; end
            endcase
         end
         OP_ADDI:  begin sel = ALU_ADD;  b = imm_sx; cls = ARITH_ADD; end
         OP_ADDIU: begin sel = ALU_ADD;  b = imm_sx; end
         OP_SLTI:  begin sel = ALU_SLT;  b = imm_sx; end
         OP_SLTIU: begin sel = ALU_SLTU; b = imm_sx; end
         OP_ANDI:  begin sel = ALU_AND;  b = imm_zx; end
         OP_ORI:   begin sel = ALU_OR;   b = imm_zx; end
         OP_BEQ:   begin sel = ALU_SUB;  b = rt; end
         default:  err = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - two-stage issue/retire wrapper around ALU_32bit with
// valid/ready on both sides, overflow trap, illegal-op flag and retire counters.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int W     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [5:0]       in_opcode,
   input  logic [5:0]       in_funct,
   input  logic [W-1:0]     in_rs,
   input  logic [W-1:0]     in_rt,
   input  logic [15:0]      in_imm,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_result,
   output logic             out_zero,
   output logic             out_carry,
   output logic             out_ovf,
   output logic             out_err,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [CNT_W-1:0] err_cnt
);

   logic             s1_valid_q, s1_valid_d;
   logic [3:0]       s1_sel_q, s1_sel_d;
   logic [W-1:0]     s1_a_q, s1_a_d;
   logic [W-1:0]     s1_b_q, s1_b_d;
   op_class_e        s1_cls_q, s1_cls_d;
   logic             s1_err_q, s1_err_d;

   logic             s2_valid_q, s2_valid_d;
   logic [W-1:0]     s2_res_q, s2_res_d;
   logic             s2_carry_q, s2_carry_d;
   logic             s2_ovf_q, s2_ovf_d;
   logic             s2_err_q, s2_err_d;

   logic [CNT_W-1:0] retired_q, retired_d;
   logic [CNT_W-1:0] errs_q, errs_d;

   logic             s1_ready, s2_ready;
   logic [3:0]       dec_sel;
   logic [W-1:0]     dec_b;
   op_class_e        dec_cls;
   logic             dec_err;
   logic [W-1:0]     alu_out;
   logic             alu_carry;

   alu_op_decode u_dec (
      .opcode (in_opcode),
      .funct  (in_funct),
      .rt     (in_rt),
      .imm    (in_imm),
      .sel    (dec_sel),
      .b      (dec_b),
      .cls    (dec_cls),
      .err    (dec_err)
   );

   ALU_32bit u_alu (
      .A        (s1_a_q),
      .B        (s1_b_q),
      .ALU_Sel  (s1_sel_q),
      .ALU_Out  (alu_out),
      .CarryOut (alu_carry)
   );

   // Ready depends only on registered valids, never on in_valid.
   assign s2_ready = !s2_valid_q || out_ready;
   assign s1_ready = !s1_valid_q || s2_ready;

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sel_d   = s1_sel_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_cls_d   = s1_cls_q;
      s1_err_d   = s1_err_q;
      s2_valid_d = s2_valid_q;
      s2_res_d   = s2_res_q;
      s2_carry_d = s2_carry_q;
      s2_ovf_d   = s2_ovf_q;
      s2_err_d   = s2_err_q;
      retired_d  = retired_q;
      errs_d     = errs_q;

      if (s1_ready) begin
         s1_valid_d = in_valid;
         if (in_valid) begin
            s1_sel_d = dec_sel;
            s1_a_d   = in_rs;
            s1_b_d   = dec_b;
            s1_cls_d = dec_cls;
            s1_err_d = dec_err;
         end
      end

      if (s2_ready) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_res_d   = s1_err_q ? '0 : alu_out;
            s2_carry_d = !s1_err_q && alu_carry;
            s2_err_d   = s1_err_q;
            case (s1_cls_q)
               ARITH_ADD: s2_ovf_d = (s1_a_q[W-1] == s1_b_q[W-1]) && (alu_out[W-1] != s1_a_q[W-1]);
               ARITH_SUB: s2_ovf_d = (s1_a_q[W-1] != s1_b_q[W-1]) && (alu_out[W-1] != s1_a_q[W-1]);
               default:   s2_ovf_d = 1'b0;
            endcase
         end
      end

      if (s2_valid_q && out_ready) begin
         retired_d = retired_q + CNT_W'(1);
         if (s2_err_q) begin
            errs_d = errs_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_sel_q   <= '0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_cls_q   <= OTHER;
         s1_err_q   <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_carry_q <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_err_q   <= 1'b0;
         retired_q  <= '0;
         errs_q     <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_sel_q   <= s1_sel_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_cls_q   <= s1_cls_d;
         s1_err_q   <= s1_err_d;
         s2_valid_q <= s2_valid_d;
         s2_res_q   <= s2_res_d;
         s2_carry_q <= s2_carry_d;
         s2_ovf_q   <= s2_ovf_d;
         s2_err_q   <= s2_err_d;
         retired_q  <= retired_d;
         errs_q     <= errs_d;
      end
   end

   assign in_ready    = s1_ready;
   assign out_valid   = s2_valid_q;
   assign out_result  = s2_res_q;
   // Zero comes from the held result so it stays 0 while idle and for errors.
   assign out_zero    = s2_valid_q && !s2_err_q && (s2_res_q == '0);
   assign out_carry   = s2_carry_q;
   assign out_ovf     = s2_ovf_q;
   assign out_err     = s2_err_q;
   assign retired_cnt = retired_q;
   assign err_cnt     = errs_q;

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Pipelined issue/retire controller that drives the 32-bit ALU (`ALU_32bit`).
- Accepts decoded-instruction fields (opcode, funct, register values, immediate) over a valid/ready handshake.
- Translates them into `ALU_SEL` and operands, and presents registered results and flags downstream over a second valid/ready handshake.
- Sits between register-read and writeback in the integer datapath.
- Flags illegal encodings and signed-overflow traps.

## Interface
Parameters:
- `W`, 32, datapath width; only 32 is supported.
- `CNT_W`, 16, width of the retired-op and error counters.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream presents an op.
- `in_ready`  out  1  block accepts the op this cycle.
- `in_opcode`  in  6  MIPS opcode.
- `in_funct`  in  6  MIPS funct; used only when `in_opcode`=0.
- `in_rs`  in  W  rs register value.
- `in_rt`  in  W  rt register value.
- `in_imm`  in  16  immediate.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  downstream consumes the result.
- `out_result`  out  W  ALU result; 0 when `out_err`=1.
- `out_zero`  out  1  zero flag of the result.
- `out_carry`  out  1  carry-out of the unsigned A+B.
- `out_ovf`  out  1  signed-overflow trap (add/addi/sub only).
- `out_err`  out  1  illegal opcode/funct.
- `retired_cnt`  out  CNT_W  count of results consumed.
- `err_cnt`  out  CNT_W  count of consumed results with `out_err`=1.

## Operation
Decode, with ALU_SEL and operand B shown for each op:
- R-type (opcode 0x00), B=rt:
  - funct 0x24 and → 0
  - funct 0x25 or → 1
  - funct 0x20 add / 0x21 addu → 2
  - funct 0x22 sub / 0x23 subu → 6
  - funct 0x2B sltu → 7
  - funct 0x2A slt → 8
  - funct 0x27 nor → 12
- I-type:
  - 0x08 addi → 2, sign-extended imm
  - 0x09 addiu → 2, sign-extended imm
  - 0x0A slti → 8, sign-extended imm
  - 0x0B sltiu → 7, sign-extended imm
  - 0x0C andi → 0, zero-extended imm
  - 0x0D ori → 1, zero-extended imm
  - 0x04 beq → 6, B=rt; only `out_zero` is meaningful.
- Operand A is always rs.
- Any other encoding: `out_err`=1, `out_result`=0, `out_ovf`=0, and the ALU select is forced to 0.
- Signed overflow trap `out_ovf`, computed from A, B and R=result in stage 2:
  - add/addi: A[31]==B[31] and R[31]!=A[31].
  - sub: A[31]!=B[31] and R[31]!=A[31].
  - 0 for every other op.
- `out_result`, `out_zero` and `out_carry` are registered copies of the ALU outputs. `out_zero` is recomputed from the registered result (0 for err).
- Counters increment on the out handshake (`out_valid`&&`out_ready`) and wrap modulo 2^CNT_W. `err_cnt` increments only when `out_err`=1.

## Timing
- Two register stages:
  - S1 holds the decoded select, A, B, op class and err.
  - S2 holds the result and flags. The ALU is combinational between S1 and S2.
- Latency: an op accepted in cycle N appears on `out_*` with `out_valid`=1 in cycle N+2, given `out_ready` held high.
- Throughput: 1 op/cycle.
- Ready rules:
  - `s2_ready = !s2_valid || out_ready`
  - `s1_ready = !s1_valid || s2_ready`
  - `in_ready = s1_ready`
- Stall behaviour: `out_*` hold stable while `out_valid`&&!`out_ready`. No op is dropped or duplicated.
- Simultaneous consume and refill: S2 reloads from S1 in the same cycle it is consumed.
- `in_ready` does not depend combinationally on `in_valid`.
- Reset (async assert, synchronous deassert by upstream):
  - All valids 0.
  - All data, flags and counters 0.
  - `in_ready`=1 in the first cycle after deassert.
  - Reset mid-stream discards both in-flight ops.

## Structure
- Shared package `alu_pkg`:
  - ALU_SEL localparams: AND=0, OR=1, ADD=2, SUB=6, SLTU=7, SLT=8, NOR=12.
  - Opcode and funct constants.
  - Op-class enum: {ARITH_ADD, ARITH_SUB, OTHER}.
- Sub-module `alu_op_decode`: purely combinational. Maps opcode/funct/imm to sel, B operand, class and err.
- Instantiates `ALU_32bit` between S1 and S2.

## Test plan
- **add, no stall:** add rs=5, rt=7 with `out_ready`=1 → in cycle N+2, `out_result`=12, zero=0, ovf=0, err=0.
- **Signed add overflow:** add rs=0x7FFFFFFF, rt=1 → result 0x80000000, `out_ovf`=1; the same operands with addu → `out_ovf`=0.
- **Immediate extension:** slti rs=0xFFFFFFFE (−2), imm=0xFFFF (−1) → result 1. sltiu rs=1, imm=0xFFFF → result 1. andi rs=0xFFFFFFFF, imm=0x8001 → 0x00008001.
- **beq and illegal:** beq rs=rt=0xA5A5A5A5 → `out_zero`=1. opcode 0x3F → `out_err`=1, result 0, `err_cnt` increments by 1 on consume.
- **Back-pressure:** issue 4 back-to-back ops with `out_ready` low for cycles 2–5 → `in_ready` drops after two ops are buffered, outputs stay stable, all 4 results arrive in order, `retired_cnt`=4.
- **Reset mid-operation:** assert `rst_n`=0 with both stages valid → `out_valid`=0 and counters=0 immediately; no stale result appears after release.
